// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transfer arbiter: state encoding, word layout, sizes.
package i2c_pkg;

  localparam int unsigned WORD_W     = 24;
  localparam int unsigned N_REQ      = 2;
  localparam logic [7:0]  CODEC_ADDR = 8'h34;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    WAIT_CLR  = 3'd3,
    RESP      = 3'd4
  } arb_state_t;

  // One transfer word as handed to i2c_ctrl.
  typedef struct packed {
    logic [7:0]  dev_addr;
    logic [15:0] reg_addr;
  } xfer_word_t;

  // One-hot completion vector for a requester index.
  function automatic logic [N_REQ-1:0] grant_onehot(input logic idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/i2c_arb_if.sv
// Requester and i2c_ctrl signals seen by the arbiter, bundled as one interface.
interface i2c_arb_if;
  import i2c_pkg::*;

  logic [N_REQ-1:0] rq_req;
  xfer_word_t       rq_data0;
  xfer_word_t       rq_data1;
  logic [N_REQ-1:0] rq_done;
  logic             rq_err;
  logic             ctl_go;
  xfer_word_t       ctl_data;
  logic             ctl_done;
  logic             ctl_nack;
  logic             busy;
  logic             owner;

  // Arbiter side.
  modport master (
    input  rq_req, rq_data0, rq_data1, ctl_done, ctl_nack,
    output rq_done, rq_err, ctl_go, ctl_data, busy, owner
  );

  // Requesters plus i2c_ctrl side.
  modport slave (
    output rq_req, rq_data0, rq_data1, ctl_done, ctl_nack,
    input  rq_done, rq_err, ctl_go, ctl_data, busy, owner
  );

endinterface

// File: rtl/i2c_rr_pick.sv
// Two-way round-robin picker: on a tie, grant the index not granted last.
module i2c_rr_pick
  import i2c_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             last,
  output logic             vld_c,
  output logic             idx_c
);

  // Winner selection from current requests and last-grant pointer.
  always_comb begin
    vld_c = |req;
    idx_c = 1'b0;
    if (&req) begin
      idx_c = ~last;
    end else begin
      idx_c = req[1];
    end
  end

endmodule

// File: rtl/i2c_arb.sv
// Arbiter sharing one i2c_ctrl between the config sequencer and runtime volume control,
// with NACK retry and per-attempt timeout.
module i2c_arb
  import i2c_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 2_000_000
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  i2c_arb_if.master  bus
);

  localparam int unsigned RETRY_CLOG = $clog2(MAX_RETRY + 1);
  localparam int unsigned RETRY_W    = (RETRY_CLOG > 2) ? RETRY_CLOG : 2;
  localparam int unsigned TMO_W      = $clog2(TIMEOUT + 1);

  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0]   TMO_SAT   = TMO_W'(TIMEOUT);

  arb_state_t         state;
  logic               done_s1;
  logic               done_s2;
  logic               done_d;
  logic               nack_q;
  logic               last_grant;
  logic [RETRY_W-1:0] retry_cnt;
  logic [TMO_W-1:0]   tmo_cnt;

  logic               pick_vld_c;
  logic               pick_idx_c;
  logic               done_rise_c;
  logic               tmo_hit_c;

  i2c_rr_pick u_pick (
    .req   (bus.rq_req),
    .last  (last_grant),
    .vld_c (pick_vld_c),
    .idx_c (pick_idx_c)
  );

  // Bring ctl_done from the slow i2c domain in; keep one extra stage for edge detect.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      done_s1 <= 1'b0;
      done_s2 <= 1'b0;
      done_d  <= 1'b0;
    end else begin
      done_s1 <= bus.ctl_done;
      done_s2 <= done_s1;
      done_d  <= done_s2;
    end
  end

  assign done_rise_c = done_s2 & ~done_d;
  // Next count would reach TIMEOUT: the attempt has run out of time.
  assign tmo_hit_c   = (tmo_cnt >= TMO_LAST);

  // Transfer FSM with registered outputs; rq_done/rq_err are high only in RESP.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bus.ctl_go   <= 1'b0;
      bus.ctl_data <= '0;
      bus.rq_done  <= '0;
      bus.rq_err   <= 1'b0;
      bus.busy     <= 1'b0;
      bus.owner    <= 1'b0;
      nack_q       <= 1'b0;
      last_grant   <= 1'b1;
      retry_cnt    <= '0;
      tmo_cnt      <= '0;
    end else begin
      bus.rq_done <= '0;
      bus.rq_err  <= 1'b0;

      if (state == WAIT_DONE || state == WAIT_CLR) begin
        tmo_cnt <= tmo_hit_c ? TMO_SAT : tmo_cnt + TMO_W'(1);
      end

      case (state)
        IDLE: begin
          if (pick_vld_c) begin
            state        <= ISSUE;
            bus.busy     <= 1'b1;
            bus.ctl_go   <= 1'b1;
            bus.owner    <= pick_idx_c;
            bus.ctl_data <= pick_idx_c ? bus.rq_data1 : bus.rq_data0;
            nack_q       <= 1'b0;
            retry_cnt    <= '0;
            tmo_cnt      <= '0;
          end
        end

        ISSUE: begin
          state <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (tmo_hit_c) begin
            state       <= RESP;
            bus.ctl_go  <= 1'b0;
            bus.rq_done <= grant_onehot(bus.owner);
            bus.rq_err  <= 1'b1;
          end else if (done_rise_c) begin
            state      <= WAIT_CLR;
            bus.ctl_go <= 1'b0;
            nack_q     <= bus.ctl_nack;
          end
        end

        WAIT_CLR: begin
          if (tmo_hit_c) begin
            state       <= RESP;
            bus.rq_done <= grant_onehot(bus.owner);
            bus.rq_err  <= 1'b1;
          end else if (!done_s2) begin
            if (nack_q && (retry_cnt < RETRY_MAX)) begin
              state      <= ISSUE;
              bus.ctl_go <= 1'b1;
              retry_cnt  <= retry_cnt + RETRY_W'(1);
              tmo_cnt    <= '0;
            end else begin
              state       <= RESP;
              bus.rq_done <= grant_onehot(bus.owner);
              bus.rq_err  <= nack_q;
            end
          end
        end

        RESP: begin
          state      <= IDLE;
          bus.busy   <= 1'b0;
          last_grant <= bus.owner;
        end

        default: begin
          state      <= IDLE;
          bus.busy   <= 1'b0;
          bus.ctl_go <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/i2c_arb.md
I2C_ARB -- requirements
Module: i2c_arb

Interface
REQ-001 Parameter MAX_RETRY, 3: re-issues allowed after a NACK before reporting error.
REQ-002 Parameter TIMEOUT, 2_000_000: clk_50m cycles allowed per transfer attempt (40 ms).
REQ-003 clk_50m  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rq_req  input  2  per-requester request level; index 0 = config sequencer, 1 = runtime volume/mute control.
REQ-006 rq_data0, rq_data1  input  24 each  transfer word {dev_addr[7:0], reg[15:0]}.
REQ-007 rq_done  output  2  one-cycle completion pulse to the owning requester.
REQ-008 rq_err  output  1  failure status, valid only while any rq_done bit is high.
REQ-009 ctl_go  output  1  start level to i2c_ctrl.
REQ-010 ctl_data  output  24  word to i2c_ctrl.
REQ-011 ctl_done  input  1  i2c_ctrl transfer-complete level (slow i2c clock domain, double-synchronised inside).
REQ-012 ctl_nack  input  1  i2c_ctrl status; high = slave did not acknowledge; sampled when synchronised ctl_done rises.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 owner  output  1  index of current grant; meaningful only while busy.

Function
REQ-015 States: IDLE, ISSUE, WAIT_DONE, WAIT_CLR, RESP; encoding 3 bits.
REQ-016 IDLE: any rq_req high -> latch winner into owner, latch its rq_data into ctl_data, clear retry and timeout counters, go ISSUE.
REQ-017 Arbitration round-robin: if both request, grant the index not granted last; last-grant pointer resets to 1, so index 0 wins first tie.
REQ-018 ISSUE: drive ctl_go=1 for that cycle and onward, go WAIT_DONE next cycle.
REQ-019 WAIT_DONE: ctl_go held 1; on synchronised ctl_done rising, capture ctl_nack, drop ctl_go, go WAIT_CLR.
REQ-020 WAIT_CLR: ctl_go 0; when synchronised ctl_done low: if captured NACK and retry count < MAX_RETRY, increment retry, reset timeout, go ISSUE; else go RESP.
REQ-021 RESP: pulse rq_done[owner] for exactly one cycle with rq_err = captured NACK or timeout flag; update last-grant pointer; return to IDLE.
REQ-022 Timeout counter runs in WAIT_DONE and WAIT_CLR, saturating width ceil(log2(TIMEOUT+1)); reaching TIMEOUT sets timeout flag, drops ctl_go, goes RESP directly with rq_err=1; no retry after timeout.
REQ-023 Retry counter width 2 bits min, sized from MAX_RETRY; MAX_RETRY=0 means a NACK errors immediately.
REQ-024 ctl_data and owner stable from IDLE exit until RESP exit; requester changing rq_data mid-transfer has no effect.
REQ-025 Requester dropping rq_req mid-transfer does not abort; rq_done still pulses.
REQ-026 A requester holding rq_req across its own rq_done is treated as a new request, subject to round-robin next cycle in IDLE.
REQ-027 Minimum gap between two grants: one IDLE cycle.

Reset
REQ-028 Asserting rst_n low at any time, including mid-transfer, returns state to IDLE immediately.
REQ-029 Reset values: ctl_go 0, ctl_data 0, rq_done 0, rq_err 0, busy 0, owner 0, counters 0, synchronisers 0, last-grant 1.
REQ-030 i2c_ctrl shares rst_n; no bus recovery sequence is issued by this block.

Structure
REQ-031 Shared package i2c_pkg holds state encoding, CODEC_ADDR 8'h34, word width 24, requester count 2.
REQ-032 One sub-module natural: i2c_rr_pick (2-way round-robin picker, combinational, from rq_req and last-grant).

Verification
REQ-033 Single req0 with 24'h34_0017, ctl_done rises 5 cycles after ctl_go, nack 0 -> ctl_data 24'h340017, rq_done=2'b01 one cycle, rq_err 0.
REQ-034 rq_req=2'b11 from reset -> req0 served first, then req1; next tie serves req0 again.
REQ-035 req1, ctl_nack=1 on every attempt, MAX_RETRY=3 -> exactly 4 ctl_go rising edges, then rq_done=2'b10 with rq_err 1.
REQ-036 NACK on first attempt, ack on second -> 2 ctl_go rising edges, rq_err 0.
REQ-037 ctl_done never rises, TIMEOUT=100 -> ctl_go drops 100 cycles after retry/timeout clear, rq_done pulses, rq_err 1.
REQ-038 rst_n low during WAIT_DONE -> ctl_go 0 and busy 0 same cycle asynchronously; no rq_done pulse follows release.
